mem_port_arbiter: RTL and testbench

Shares the memory controller's single CPU/data read-write port among three requesters: the CPU mem stage, the image processor and the SPART read path. Fixed priority (CPU > IMG > SPART) with aging, so IMG and SPART cannot starve. Adds a per-access timeout. Sits between the requesters and the memory controller's cpu_rw_* interface; the instruction ROM port is not arbitrated.

---
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the memory controller's single read/write port
// between the CPU, the image processor and the SPART read path. Fixed
// priority CPU > IMG > SPART, with aging so that a long-waiting IMG or SPART
// request is promoted above the CPU, and a per-access timeout that returns
// ERR_DATA with err set.
module mem_port_arbiter #(
  parameter int          STARVE_LIMIT = 16,
  parameter int          TIMEOUT      = 64,
  parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  output logic        cpu_vld,
  input  logic        img_req,
  input  logic        img_wr,
  input  logic [31:0] img_addr,
  input  logic [31:0] img_wr_data,
  output logic        img_vld,
  input  logic        spart_req,
  input  logic [31:0] spart_addr,
  output logic        spart_vld,
  output logic [31:0] rd_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_vld
);

  localparam int WCW = $clog2(STARVE_LIMIT + 1);
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCW-1:0] W_LIM   = WCW'(STARVE_LIMIT);
  localparam logic [TCW-1:0] TO_LAST = TCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_CPU, G_IMG, G_SPART} grant_t;

  state_t         state, state_next;
  grant_t         grant, win;
  logic [WCW-1:0] img_wait, spart_wait;
  logic [TCW-1:0] to_cnt;
  logic           timed_out;

  // The timeout only fires when no completion arrives in the same cycle.
  assign timed_out = (TIMEOUT != 0) && (state == ISSUE) && !mem_vld && (to_cnt == TO_LAST);

  assign mem_req   = (state == ISSUE);
  assign cpu_vld   = (state == DONE) && (grant == G_CPU);
  assign img_vld   = (state == DONE) && (grant == G_IMG);
  assign spart_vld = (state == DONE) && (grant == G_SPART);

  // Pick the winner in IDLE: starved SPART, starved IMG, CPU, IMG, SPART.
  always_comb begin
    win = G_NONE;
    if (state == IDLE) begin
      if (spart_req && (spart_wait >= W_LIM))  win = G_SPART;
      else if (img_req && (img_wait >= W_LIM)) win = G_IMG;
      else if (cpu_req)                        win = G_CPU;
      else if (img_req)                        win = G_IMG;
      else if (spart_req)                      win = G_SPART;
    end
  end

  // Next-state logic for the IDLE -> ISSUE -> DONE access sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win != G_NONE) state_next = ISSUE;
      ISSUE:   if (mem_vld || timed_out) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, grant, captured access fields, read data and timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= G_NONE;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      rd_data     <= '0;
      err         <= 1'b0;
      to_cnt      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (win != G_NONE) grant <= win;
          case (win)
            G_CPU: begin
              mem_wr      <= cpu_wr;
              mem_addr    <= cpu_addr;
              mem_wr_data <= cpu_wr_data;
            end
            G_IMG: begin
              mem_wr      <= img_wr;
              mem_addr    <= img_addr;
              mem_wr_data <= img_wr_data;
            end
            G_SPART: begin
              mem_wr      <= 1'b0;
              mem_addr    <= spart_addr;
            end
            default: ;
          endcase
        end
        ISSUE: begin
          to_cnt <= to_cnt + 1'b1;
          if (mem_vld) begin
            rd_data <= mem_rd_data;
            err     <= 1'b0;
          end else if (timed_out) begin
            rd_data <= ERR_DATA;
            err     <= 1'b1;
          end
        end
        DONE: begin
          grant <= G_NONE;
          err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Aging counters: count waiting cycles, clear on grant or dropped request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_wait   <= '0;
      spart_wait <= '0;
    end else begin
      if (!img_req || (win == G_IMG))
        img_wait <= '0;
      else if ((grant != G_IMG) && (img_wait < W_LIM))
        img_wait <= img_wait + 1'b1;

      if (!spart_req || (win == G_SPART))
        spart_wait <= '0;
      else if ((grant != G_SPART) && (spart_wait < W_LIM))
        spart_wait <= spart_wait + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int SL = 4;
  localparam int TO = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_wr, img_req, img_wr, spart_req, mem_vld;
  logic [31:0] cpu_addr, cpu_wr_data, img_addr, img_wr_data, spart_addr, mem_rd_data;
  logic        cpu_vld, img_vld, spart_vld, err, mem_req, mem_wr;
  logic [31:0] rd_data, mem_addr, mem_wr_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_vld(cpu_vld),
    .img_req(img_req), .img_wr(img_wr), .img_addr(img_addr), .img_wr_data(img_wr_data),
    .img_vld(img_vld),
    .spart_req(spart_req), .spart_addr(spart_addr), .spart_vld(spart_vld),
    .rd_data(rd_data), .err(err),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_vld(mem_vld)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = waiting for work, 1 = access in flight,
  // 2 = completion cycle. owner: 0 none, 1 cpu, 2 img, 3 spart.
  int          ph, owner, issue_cycles, age_img, age_sp;
  bit          e_wr, e_err;
  logic [31:0] e_addr, e_wdata, e_rd;

  function automatic void model_reset();
    ph = 0; owner = 0; issue_cycles = 0; age_img = 0; age_sp = 0;
    e_wr = 0; e_err = 0; e_addr = '0; e_wdata = '0; e_rd = '0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    int pick;
    pick = 0;
    if (ph == 0) begin
      if (spart_req && age_sp >= SL)       pick = 3;
      else if (img_req && age_img >= SL)   pick = 2;
      else if (cpu_req)                    pick = 1;
      else if (img_req)                    pick = 2;
      else if (spart_req)                  pick = 3;
    end
    if (!img_req || pick == 2)             age_img = 0;
    else if (!(ph != 0 && owner == 2))     age_img = (age_img + 1 > SL) ? SL : age_img + 1;
    if (!spart_req || pick == 3)           age_sp = 0;
    else if (!(ph != 0 && owner == 3))     age_sp = (age_sp + 1 > SL) ? SL : age_sp + 1;

    if (ph == 0) begin
      if (pick != 0) begin
        owner = pick;
        issue_cycles = 0;
        ph = 1;
        if (pick == 1) begin e_wr = cpu_wr; e_addr = cpu_addr; e_wdata = cpu_wr_data; end
        else if (pick == 2) begin e_wr = img_wr; e_addr = img_addr; e_wdata = img_wr_data; end
        else begin e_wr = 0; e_addr = spart_addr; end
      end
    end else if (ph == 1) begin
      issue_cycles++;
      if (mem_vld) begin
        e_rd = mem_rd_data; e_err = 0; ph = 2;
      end else if (TO != 0 && issue_cycles >= TO) begin
        e_rd = ERRD; e_err = 1; ph = 2;
      end
    end else begin
      ph = 0; owner = 0; e_err = 0;
    end
  endfunction

  task automatic check_outputs();
    chk("mem_req",     32'(mem_req),   32'(ph == 1));
    chk("mem_wr",      32'(mem_wr),    32'(e_wr));
    chk("mem_addr",    mem_addr,       e_addr);
    chk("mem_wr_data", mem_wr_data,    e_wdata);
    chk("cpu_vld",     32'(cpu_vld),   32'(ph == 2 && owner == 1));
    chk("img_vld",     32'(img_vld),   32'(ph == 2 && owner == 2));
    chk("spart_vld",   32'(spart_vld), 32'(ph == 2 && owner == 3));
    chk("rd_data",     rd_data,        e_rd);
    chk("err",         32'(err),       32'(e_err));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drop_all();
    cpu_req = 0; img_req = 0; spart_req = 0;
  endtask

  // Randomized requester and memory behaviour, applied just after an edge.
  task automatic random_agents();
    if (cpu_req && cpu_vld) begin
      if ($urandom_range(1, 0) == 1) cpu_req = 0;
      else begin cpu_wr = 1'($urandom); cpu_addr = $urandom; cpu_wr_data = $urandom; end
    end else if (!cpu_req && $urandom_range(3, 0) == 0) begin
      cpu_req = 1; cpu_wr = 1'($urandom); cpu_addr = $urandom; cpu_wr_data = $urandom;
    end
    if (img_req && img_vld) begin
      if ($urandom_range(1, 0) == 1) img_req = 0;
      else begin img_wr = 1'($urandom); img_addr = $urandom; img_wr_data = $urandom; end
    end else if (!img_req && $urandom_range(3, 0) == 0) begin
      img_req = 1; img_wr = 1'($urandom); img_addr = $urandom; img_wr_data = $urandom;
    end
    if (spart_req && spart_vld) begin
      if ($urandom_range(1, 0) == 1) spart_req = 0;
      else spart_addr = $urandom;
    end else if (!spart_req && $urandom_range(3, 0) == 0) begin
      spart_req = 1; spart_addr = $urandom;
    end
    mem_vld     = ($urandom_range(3, 0) == 0);
    mem_rd_data = $urandom;
  endtask

  initial begin
    bit seen;
    int cnt;
    rst_n = 0;
    drop_all();
    cpu_wr = 0; img_wr = 0; mem_vld = 0;
    cpu_addr = '0; cpu_wr_data = '0; img_addr = '0; img_wr_data = '0;
    spart_addr = '0; mem_rd_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1;

    // Single CPU read.
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h10;
    tick();
    chk("cpu_rd_addr", mem_addr, 32'h10);
    chk("cpu_rd_req", 32'(mem_req), 32'd1);
    mem_vld = 1; mem_rd_data = 32'h1234;
    tick();
    chk("cpu_rd_vld", 32'(cpu_vld), 32'd1);
    chk("cpu_rd_data", rd_data, 32'h1234);
    cpu_req = 0; mem_vld = 0;
    tick();
    chk("cpu_rd_once", 32'(cpu_vld), 32'd0);

    // Simultaneous CPU write and IMG read: CPU first, then IMG.
    cpu_req = 1; cpu_wr = 1; cpu_addr = 32'h20; cpu_wr_data = 32'hCAFE;
    img_req = 1; img_wr = 0; img_addr = 32'h30;
    tick();
    chk("cpu_wr_first", 32'(mem_wr), 32'd1);
    chk("cpu_wr_data", mem_wr_data, 32'hCAFE);
    mem_vld = 1; mem_rd_data = 32'h0;
    tick();
    chk("cpu_wr_vld", 32'(cpu_vld), 32'd1);
    cpu_req = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (img_vld) seen = 1;
    end
    chk("img_after_cpu", 32'(seen), 32'd1);
    chk("img_addr", mem_addr, 32'h30);
    img_req = 0; mem_vld = 0;
    tick();

    // Starvation: CPU re-requests back-to-back while SPART is held.
    spart_req = 1; spart_addr = 32'h60;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h70;
    mem_vld = 1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (spart_vld) seen = 1;
      if (cpu_vld) cpu_addr = cpu_addr + 32'h4;
    end
    chk("starved_spart", 32'(seen), 32'd1);
    chk("starved_cpu_pending", 32'(cpu_req), 32'd1);
    drop_all(); mem_vld = 0;
    tick(); tick(); tick(); tick();

    // Timeout on an IMG read, then a normal access.
    img_req = 1; img_wr = 0; img_addr = 32'h80;
    cnt = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (mem_req) cnt++;
      if (img_vld) seen = 1;
    end
    chk("to_vld", 32'(seen), 32'd1);
    chk("to_issue_cycles", 32'(cnt), 32'd8);
    chk("to_err", 32'(err), 32'd1);
    chk("to_data", rd_data, ERRD);
    img_req = 0;
    tick();
    img_req = 1; img_addr = 32'h90; mem_vld = 1; mem_rd_data = 32'hABCD;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      tick();
      if (img_vld) seen = 1;
    end
    chk("after_to_vld", 32'(seen), 32'd1);
    chk("after_to_data", rd_data, 32'hABCD);
    chk("after_to_err", 32'(err), 32'd0);
    img_req = 0; mem_vld = 0;
    tick();

    // Stray mem_vld with nothing in flight.
    mem_vld = 1; mem_rd_data = 32'h5555AAAA;
    tick(); tick();
    chk("stray_rd", rd_data, 32'hABCD);
    mem_vld = 0;

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      random_agents();
      tick();
    end

    // Settle to idle, then reset in the middle of an access.
    drop_all(); mem_vld = 1;
    repeat (4) tick();
    mem_vld = 0;
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h44;
    tick();
    chk("pre_rst_issue", 32'(mem_req), 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_vld", {29'd0, cpu_vld, img_vld, spart_vld}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    cpu_req = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    check_outputs();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 32'h50; mem_vld = 1; mem_rd_data = 32'h5555;
    tick();
    tick();
    chk("post_rst_vld", 32'(cpu_vld), 32'd1);
    chk("post_rst_data", rd_data, 32'h5555);
    cpu_req = 0; mem_vld = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
